// File: rtl/rv_regs_pkg.sv
// Shared register-file sizing: entry count, index width and index type.
package rv_regs_pkg;
  localparam int NUM_REGS = 32;
  localparam int IDX_W    = 5;

  typedef logic [IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/decoder5to32.sv
// Index-to-one-hot decode with enable; all zeros when disabled.
module decoder5to32
  import rv_regs_pkg::*;
(
  input  reg_idx_t              idx,
  input  logic                  en,
  output logic [NUM_REGS-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/reg_bank32.sv
// 32-entry register bank with per-entry pending-write scoreboard and a sticky
// flag for writebacks that arrive without a matching claim. Entry 0 reads as 0.
module reg_bank32
  import rv_regs_pkg::*;
#(
  parameter int width = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               alloc_valid,
  input  reg_idx_t                           alloc_idx,
  input  logic                               wb_valid,
  input  reg_idx_t                           wb_idx,
  input  logic [width-1:0]                   wb_data,
  input  logic                               flush,
  output logic [NUM_REGS-1:0][width-1:0]     entries,
  output logic [NUM_REGS-1:0]                busy,
  output logic                               wb_err
);

  logic [NUM_REGS-1:0]          wb_we;
  logic [NUM_REGS-1:0]          alloc_set;
  logic [NUM_REGS-1:0]          busy_q;
  logic [NUM_REGS-1:0]          busy_nxt;
  logic [NUM_REGS-1:1][width-1:0] regs;
  logic                         err_q;
  logic                         err_set;

  decoder5to32 u_wb_dec (
    .idx    (wb_idx),
    .en     (wb_valid),
    .onehot (wb_we)
  );

  decoder5to32 u_alloc_dec (
    .idx    (alloc_idx),
    .en     (alloc_valid),
    .onehot (alloc_set)
  );

  // Entry 0 has no storage at all, so it cannot be written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wb_we[i]) regs[i] <= wb_data;
      end
    end
  end

  assign entries = {regs, {width{1'b0}}};

  // Claim is applied after the writeback clear so a same-index claim wins.
  always_comb begin
    busy_nxt = '0;
    if (!flush) busy_nxt = (busy_q & ~wb_we) | alloc_set;
    busy_nxt[0] = 1'b0;
  end

  assign err_set = wb_valid && (wb_idx != '0) && !busy_q[wb_idx] && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      if (err_set) err_q <= 1'b1;
    end
  end

  assign busy   = busy_q;
  assign wb_err = err_q;

endmodule

// File: tb/tb_reg_bank32.sv
// Self-checking bench for reg_bank32: directed vector table, corner sequences
// around async reset, and randomized traffic against a behavioural model.
module tb_reg_bank32;
  import rv_regs_pkg::*;

  localparam int W = 32;

  logic                           clk = 1'b0;
  logic                           rst_n = 1'b0;
  logic                           av = 1'b0;
  reg_idx_t                       ai = '0;
  logic                           wv = 1'b0;
  reg_idx_t                       wi = '0;
  logic [W-1:0]                   wd = '0;
  logic                           fl = 1'b0;
  logic [NUM_REGS-1:0][W-1:0]     entries;
  logic [NUM_REGS-1:0]            busy;
  logic                           wb_err;

  reg_bank32 #(.width(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_valid (av),
    .alloc_idx   (ai),
    .wb_valid    (wv),
    .wb_idx      (wi),
    .wb_data     (wd),
    .flush       (fl),
    .entries     (entries),
    .busy        (busy),
    .wb_err      (wb_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [W-1:0] m_e [NUM_REGS];
  logic         m_b [NUM_REGS];
  logic         m_err;

  typedef struct {
    logic        av;
    logic [4:0]  ai;
    logic        wv;
    logic [4:0]  wi;
    logic [31:0] wd;
    logic        fl;
    int          ci;
    logic [31:0] ee;
    logic [31:0] eb;
    logic        er;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < NUM_REGS; i++) v[i] = m_b[i];
    return v;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < NUM_REGS; i++) begin
      m_e[i] = '0;
      m_b[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  // One clock edge of architectural behaviour, from the rules directly.
  task automatic mdl_edge();
    if (wv && wi != 0) begin
      m_e[wi] = wd;
      if (!m_b[wi] && !fl) m_err = 1'b1;
    end
    if (fl) begin
      for (int i = 0; i < NUM_REGS; i++) m_b[i] = 1'b0;
    end else begin
      if (wv && wi != 0) m_b[wi] = 1'b0;
      if (av && ai != 0) m_b[ai] = 1'b1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) mdl_edge();
    #1;
  endtask

  task automatic idle();
    av = 1'b0; ai = '0; wv = 1'b0; wi = '0; wd = '0; fl = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    int bad;
    bad = -1;
    chk({tag, " busy"}, busy, m_busy_vec());
    chk({tag, " wb_err"}, {31'b0, wb_err}, {31'b0, m_err});
    for (int i = NUM_REGS - 1; i >= 0; i--)
      if (entries[i] !== m_e[i]) bad = i;
    if (bad < 0) bad = NUM_REGS - 1;
    chk($sformatf("%s entries[%0d]", tag, bad), entries[bad], m_e[bad]);
  endtask

  task automatic async_reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    mdl_reset();
    #1 compare_all(tag);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    mdl_reset();
    idle();

    tbl[0] = '{1'b1, 5'd5, 1'b0, 5'd0, 32'h0,        1'b0, 5, 32'h0,        32'h0000_0020, 1'b0};
    tbl[1] = '{1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5, 32'hDEADBEEF, 32'h0,         1'b0};
    tbl[2] = '{1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 0, 32'h0,        32'h0,         1'b0};
    tbl[3] = '{1'b1, 5'd7, 1'b0, 5'd0, 32'h0,        1'b0, 7, 32'h0,        32'h0000_0080, 1'b0};
    tbl[4] = '{1'b1, 5'd7, 1'b1, 5'd7, 32'h12,       1'b0, 7, 32'h12,       32'h0000_0080, 1'b0};
    tbl[5] = '{1'b1, 5'd3, 1'b0, 5'd0, 32'h0,        1'b0, 3, 32'h0,        32'h0000_0088, 1'b0};
    tbl[6] = '{1'b1, 5'd9, 1'b0, 5'd0, 32'h0,        1'b0, 9, 32'h0,        32'h0000_0288, 1'b0};
    tbl[7] = '{1'b1, 5'd3, 1'b1, 5'd9, 32'h55,       1'b1, 9, 32'h55,       32'h0,         1'b0};

    // Reset state, with traffic presented that must be discarded.
    av = 1'b1; ai = 5'd4; wv = 1'b1; wi = 5'd6; wd = 32'h1234_5678;
    cyc();
    cyc();
    compare_all("reset");
    idle();
    #3 rst_n = 1'b1;

    // Directed vector table.
    foreach (tbl[k]) begin
      av = tbl[k].av; ai = tbl[k].ai; wv = tbl[k].wv; wi = tbl[k].wi;
      wd = tbl[k].wd; fl = tbl[k].fl;
      cyc();
      idle();
      chk($sformatf("vec%0d entries[%0d]", k, tbl[k].ci), entries[tbl[k].ci], tbl[k].ee);
      chk($sformatf("vec%0d busy", k), busy, tbl[k].eb);
      chk($sformatf("vec%0d wb_err", k), {31'b0, wb_err}, {31'b0, tbl[k].er});
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      logic [31:0] exp;
      exp = (i == 5) ? 32'hDEADBEEF : (i == 7) ? 32'h12 : (i == 9) ? 32'h55 : 32'h0;
      if (entries[i] !== exp) chk($sformatf("table entries[%0d]", i), entries[i], exp);
    end
    compare_all("table");

    // Unclaimed writeback sets the sticky error; legal traffic keeps it.
    wv = 1'b1; wi = 5'd12; wd = 32'hC0FFEE;
    cyc();
    idle();
    chk("err set", {31'b0, wb_err}, 32'd1);
    av = 1'b1; ai = 5'd4;
    cyc();
    idle();
    wv = 1'b1; wi = 5'd4; wd = 32'h44;
    cyc();
    idle();
    cyc();
    chk("err sticky", {31'b0, wb_err}, 32'd1);
    compare_all("sticky");
    #2 rst_n = 1'b0;
    mdl_reset();
    #1 chk("err async clear", {31'b0, wb_err}, 32'd0);
    chk("entries[4] async clear", entries[4], 32'h0);
    #2 rst_n = 1'b1;

    // First edge after reset release accepts a claim.
    av = 1'b1; ai = 5'd2;
    cyc();
    idle();
    chk("claim after reset", busy, 32'h0000_0004);

    // Randomized traffic; writebacks mostly target a busy entry.
    for (int n = 0; n < 400; n++) begin
      av = 1'($urandom_range(0, 1));
      ai = 5'($urandom_range(0, 31));
      wv = 1'($urandom_range(0, 1));
      wi = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) begin
        for (int j = 0; j < NUM_REGS; j++) begin
          int c;
          c = (int'(wi) + j) % NUM_REGS;
          if (m_b[c]) begin
            wi = 5'(c);
            break;
          end
        end
      end
      wd = $urandom;
      fl = ($urandom_range(0, 15) == 0);
      cyc();
      compare_all($sformatf("rand%0d", n));
      if ($urandom_range(0, 63) == 0) async_reset_pulse($sformatf("rand%0d rst", n));
    end
    idle();
    cyc();

    // Fill every writable entry, then reset asynchronously mid-cycle.
    for (int i = 1; i < NUM_REGS; i++) begin
      wv = 1'b1; wi = 5'(i); wd = 32'hA5A5A5A5;
      cyc();
    end
    idle();
    chk("fill entries[31]", entries[31], 32'hA5A5A5A5);
    chk("fill entries[0]", entries[0], 32'h0);
    compare_all("fill");
    #2 rst_n = 1'b0;
    #1;
    begin
      int nz;
      nz = 0;
      for (int i = 0; i < NUM_REGS; i++) if (entries[i] !== '0) nz++;
      chk("async clear nonzero count", nz, 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/reg_bank32.md
REG_BANK32 -- requirements
Module: reg_bank32

Interface
REQ-001 SHALL have parameter: width, 32, data width of each entry.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: alloc_valid  input  1  a decoded instruction claims a destination register this cycle.
REQ-005 SHALL have port: alloc_idx  input  5  destination index being claimed.
REQ-006 SHALL have port: wb_valid  input  1  writeback of a result this cycle.
REQ-007 SHALL have port: wb_idx  input  5  writeback destination index.
REQ-008 SHALL have port: wb_data  input  width  writeback value.
REQ-009 SHALL have port: flush  input  1  discard all pending claims.
REQ-010 SHALL have port: entries  output  32 x width  current contents of all 32 entries; feeds external 32:1 read selectors.
REQ-011 SHALL have port: busy  output  32  per-entry pending-write flag.
REQ-012 SHALL have port: wb_err  output  1  sticky flag: a writeback targeted an entry with no pending claim.

Function
REQ-013 SHALL decode wb_idx into a 32-bit one-hot write enable, gated by wb_valid.
REQ-014 SHALL write wb_data into entries[wb_idx] on the rising edge when wb_valid=1 and wb_idx!=0; the new value is visible on entries one cycle later; no same-cycle bypass.
REQ-015 SHALL hold entries[0] at 0 permanently; writes, claims and writeback clears to index 0 have no effect, and busy[0] is always 0.
REQ-016 SHALL set busy[alloc_idx] on the rising edge when alloc_valid=1 and alloc_idx!=0.
REQ-017 SHALL clear busy[wb_idx] on the rising edge when wb_valid=1 and wb_idx!=0.
REQ-018 SHALL leave busy[i]=1 after the edge when a claim and a writeback target the same index i in the same cycle; the claim wins.
REQ-019 SHALL clear all busy bits on the rising edge when flush=1, overriding any same-cycle claim.
REQ-020 SHALL still perform the data write of a writeback that coincides with flush.
REQ-021 SHALL set wb_err when wb_valid=1, wb_idx!=0, busy[wb_idx]=0 and flush=0.
REQ-022 SHALL keep wb_err at 1 once set; only reset clears it.
REQ-023 SHALL NOT set wb_err for a writeback to index 0.
REQ-024 SHALL update only the addressed entry on a write; all other entries hold their values.

Reset
REQ-025 SHALL, while rst_n=0 and independent of clk, force all entries to 0, busy to 0 and wb_err to 0.
REQ-026 SHALL discard any claim or writeback presented in the cycle that reset asserts.
REQ-027 SHALL accept a claim or writeback on the first rising edge after rst_n deasserts.

Structure
REQ-028 SHALL take NUM_REGS=32, IDX_W=5 and typedef reg_idx_t (logic [IDX_W-1:0]) from the shared package rv_regs_pkg.
REQ-029 SHALL implement the one-hot write decode as sub-module decoder5to32 (input 5-bit index plus enable; output 32-bit one-hot), reusable wherever an index-to-one-hot decode is needed.

Verification
REQ-030 SHALL cover: reset, then wb_valid=1 with wb_idx=5 and wb_data=0xDEADBEEF, after alloc 5 one cycle earlier -> entries[5]=0xDEADBEEF on the next cycle, busy[5] returns to 0, wb_err=0, all other entries 0.
REQ-031 SHALL cover: alloc_idx=0 together with a writeback of 0xFFFFFFFF to index 0 -> entries[0]=0, busy[0]=0, wb_err=0.
REQ-032 SHALL cover: the same cycle carries alloc_idx=7 and a writeback to index 7 with data 0x12 (7 previously busy) -> entries[7]=0x12 and busy[7]=1.
REQ-033 SHALL cover: busy[3]=1 and busy[9]=1, then flush=1 with alloc_idx=3 and a writeback of 0x55 to index 9 -> busy all 0, entries[9]=0x55, wb_err=0.
REQ-034 SHALL cover: a writeback to non-busy index 12 -> wb_err=1 from the next cycle and it stays 1 through further legal traffic, until rst_n pulses low, which clears it asynchronously mid-cycle.
REQ-035 SHALL cover: write 0xA5A5A5A5 to all 31 writable indices in sequence, then assert rst_n=0 mid-cycle -> all entries read 0 immediately without waiting for a clk edge.
